// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the common data bus arbiter.
//   cdb_packet_t : one CDB broadcast / one functional-unit result
//   width_of()   : index width for a value range, never below 1 bit
package cdb_arbiter_pkg;

  localparam int NUM_FU_ALU       = 2;
  localparam int NUM_FU_MULT      = 1;
  localparam int NUM_FU_LOAD      = 1;
  localparam int NUM_FU_TOTAL     = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
  localparam int CDB_N            = 2;
  localparam int CDB_STARVE_LIMIT = 4;
  localparam int PRN_W            = 6;
  localparam int XLEN             = 32;

  typedef logic [$clog2(NUM_FU_TOTAL)-1:0] cdb_req_idx_t;

  typedef struct packed {
    logic             valid;
    logic [PRN_W-1:0] dest_prn;
    logic [XLEN-1:0]  value;
  } cdb_packet_t;

  function automatic int width_of(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_psel.sv
// Rotating-priority multi-grant selector (combinational).
//   req_i        : eligible requesters
//   rr_ptr_i     : requester scanned first
//   mask_i       : requesters already granted elsewhere (excluded)
//   first_lane_i : 1 when lane 0 is already taken, rotation starts at lane 1
//   gnt_bus_o    : one-hot grant per lane (all-zero = lane unused)
//   last_idx_o   : requester index of the last rotation grant
//   any_gnt_o    : at least one rotation grant issued
module cdb_arbiter_rr_psel
  import cdb_arbiter_pkg::*;
#(
  parameter  int N     = CDB_N,
  parameter  int REQS  = NUM_FU_TOTAL,
  localparam int IDX_W = width_of(REQS)
) (
  input  logic [REQS-1:0]         req_i,
  input  logic [IDX_W-1:0]        rr_ptr_i,
  input  logic [REQS-1:0]         mask_i,
  input  logic                    first_lane_i,
  output logic [N-1:0][REQS-1:0]  gnt_bus_o,
  output logic [IDX_W-1:0]        last_idx_o,
  output logic                    any_gnt_o
);

  logic [2*REQS-1:0]       req_dbl;
  logic [2*REQS-1:0]       req_shift;
  logic [REQS-1:0]         rot_req;
  logic [N-1:0][REQS-1:0]  rot_gnt;
  logic [2*REQS-1:0]       gnt_dbl;
  logic [IDX_W:0]          last_sum;
  int                      cnt;
  int                      last_k;

  // Work in a rotated frame where position k is requester (rr_ptr + k) mod REQS,
  // so a plain low-to-high scan gives rotating priority; rotate back afterwards.
  always_comb begin
    req_dbl   = {req_i & ~mask_i, req_i & ~mask_i};
    req_shift = req_dbl >> rr_ptr_i;
    rot_req   = req_shift[REQS-1:0];
    rot_gnt   = '0;
    gnt_bus_o = '0;
    gnt_dbl   = '0;
    any_gnt_o = 1'b0;
    last_k    = 0;
    cnt       = first_lane_i ? 1 : 0;
    for (int k = 0; k < REQS; k++) begin
      if (rot_req[k] && (cnt < N)) begin
        for (int l = 0; l < N; l++) begin
          if (cnt == l) rot_gnt[l][k] = 1'b1;
        end
        last_k    = k;
        any_gnt_o = 1'b1;
        cnt       = cnt + 1;
      end
    end
    for (int l = 0; l < N; l++) begin
      gnt_dbl      = {rot_gnt[l], rot_gnt[l]} << rr_ptr_i;
      gnt_bus_o[l] = gnt_dbl[2*REQS-1:REQS];
    end
    last_sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(last_k);
    if (last_sum >= (IDX_W+1)'(REQS)) last_sum = last_sum - (IDX_W+1)'(REQS);
    last_idx_o = last_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to N completing functional units per cycle
// onto the CDB and drives the registered broadcast one cycle later.
//   clock, reset  : rising-edge clock, asynchronous active-low reset
//   squash        : pipeline flush, no grants this cycle
//   fu_result     : per-FU result, .valid is the request
//   fu_ack        : combinational grant/acknowledge per FU
//   cdb_packet    : registered broadcast lanes
//   dbg_rr_ptr_o  : current rotation pointer (observability)
// Handshake: fu_result[i].valid is the request and its payload must stay
// stable until fu_ack[i] is seen high in the same cycle; the FU may then drop
// or replace it on the next cycle (a replacement is a brand-new request).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N            = CDB_N,
  parameter  int REQS         = NUM_FU_TOTAL,
  parameter  int STARVE_LIMIT = CDB_STARVE_LIMIT,
  localparam int IDX_W        = width_of(REQS),
  localparam int CNT_W        = width_of(STARVE_LIMIT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  cdb_packet_t [REQS-1:0] fu_result,
  output logic [REQS-1:0]        fu_ack,
  output cdb_packet_t [N-1:0]    cdb_packet,
  output logic [IDX_W-1:0]       dbg_rr_ptr_o
);

  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [REQS-1:0][CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  cdb_packet_t [N-1:0]         cdb_q, cdb_d;

  logic [REQS-1:0]             req;
  logic [REQS-1:0]             frc_oh;
  logic                        frc_vld;
  logic [N-1:0][REQS-1:0]      rot_gnt;
  logic [N-1:0][REQS-1:0]      lane_gnt;
  logic [REQS-1:0]             gnt_any;
  logic [IDX_W-1:0]            rot_last;
  logic                        rot_any;

  always_comb begin
    for (int i = 0; i < REQS; i++) req[i] = fu_result[i].valid & ~squash;
  end

  // Starvation pre-pick: descending scan so the lowest starved index wins.
  always_comb begin
    frc_vld = 1'b0;
    frc_oh  = '0;
    for (int i = REQS - 1; i >= 0; i--) begin
      if (req[i] && (wait_cnt_q[i] >= CNT_W'(STARVE_LIMIT))) begin
        frc_vld   = 1'b1;
        frc_oh    = '0;
        frc_oh[i] = 1'b1;
      end
    end
  end

  cdb_arbiter_rr_psel #(
    .N    (N),
    .REQS (REQS)
  ) u_psel (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .mask_i       (frc_oh),
    .first_lane_i (frc_vld),
    .gnt_bus_o    (rot_gnt),
    .last_idx_o   (rot_last),
    .any_gnt_o    (rot_any)
  );

  // Lane merge: the forced grant owns lane 0; rotation already skipped it.
  always_comb begin
    lane_gnt = rot_gnt;
    if (frc_vld) lane_gnt[0] = frc_oh;
    gnt_any = '0;
    for (int l = 0; l < N; l++) gnt_any = gnt_any | lane_gnt[l];
  end

  assign fu_ack = reset ? gnt_any : '0;

  always_comb begin
    for (int l = 0; l < N; l++) begin
      cdb_d[l] = '0;
      for (int i = 0; i < REQS; i++) begin
        if (lane_gnt[l][i]) cdb_d[l] = fu_result[i];
      end
      cdb_d[l].valid = |lane_gnt[l];
    end
  end

  // Only rotation grants advance the pointer; forced grants leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rot_any) rr_ptr_d = (rot_last == IDX_W'(REQS - 1)) ? '0 : rot_last + IDX_W'(1);
  end

  always_comb begin
    for (int i = 0; i < REQS; i++) begin
      if (!req[i] || gnt_any[i])
        wait_cnt_d[i] = '0;
      else if (wait_cnt_q[i] != CNT_W'(STARVE_LIMIT))
        wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
      else
        wait_cnt_d[i] = wait_cnt_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      cdb_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      cdb_q      <= cdb_d;
    end
  end

  assign cdb_packet   = cdb_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int PW = $bits(cdb_packet_t);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  // Instance 0: N=2, REQS=4, STARVE_LIMIT=4. Instance 1: N=1, REQS=4,
  // STARVE_LIMIT=2 so the starvation guard is reachable.
  cdb_packet_t           fu_v [2][4];
  logic                  sq_v [2];
  cdb_packet_t [3:0]     fu_a, fu_b;
  logic [3:0]            ack_a, ack_b;
  cdb_packet_t [1:0]     cdb_a;
  cdb_packet_t [0:0]     cdb_b;
  logic [1:0]            rr_a, rr_b;

  assign fu_a = {fu_v[0][3], fu_v[0][2], fu_v[0][1], fu_v[0][0]};
  assign fu_b = {fu_v[1][3], fu_v[1][2], fu_v[1][1], fu_v[1][0]};

  cdb_arbiter #(.N(2), .REQS(4), .STARVE_LIMIT(4)) dut_a (
    .clock(clock), .reset(reset), .squash(sq_v[0]), .fu_result(fu_a),
    .fu_ack(ack_a), .cdb_packet(cdb_a), .dbg_rr_ptr_o(rr_a));

  cdb_arbiter #(.N(1), .REQS(4), .STARVE_LIMIT(2)) dut_b (
    .clock(clock), .reset(reset), .squash(sq_v[1]), .fu_result(fu_b),
    .fu_ack(ack_b), .cdb_packet(cdb_b), .dbg_rr_ptr_o(rr_b));

  // ---------------- scoreboard / model state ----------------
  logic [PW-1:0] exp_q_a[$];
  logic [PW-1:0] exp_q_b[$];
  int            m_rr [2];
  int            m_wait [2][4];
  logic [3:0]    s_ack [2];
  int            s_rr [2];
  cdb_packet_t   s_cdb_a0, s_cdb_a1;
  int            lat [4];
  int            max_lat;
  int            n_cmp;
  int            n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic cdb_packet_t cdb_of(input int inst, input int l);
    if (inst == 1) return cdb_b[0];
    return (l == 0) ? cdb_a[0] : cdb_a[1];
  endfunction

  task automatic model_reset();
    exp_q_a.delete();
    exp_q_b.delete();
    for (int k = 0; k < 2; k++) begin
      m_rr[k]  = 0;
      s_ack[k] = '0;
      for (int i = 0; i < 4; i++) m_wait[k][i] = 0;
    end
    for (int i = 0; i < 4; i++) lat[i] = 0;
  endtask

  // ---------------- driver ----------------
  // Requested slots keep their payload while still unacknowledged; an acked or
  // idle slot that is requested again gets fresh random data.
  task automatic drive(input int inst, input logic [3:0] pat, input logic sq);
    sq_v[inst] = sq;
    for (int i = 0; i < 4; i++) begin
      if (pat[i]) begin
        if (!fu_v[inst][i].valid || s_ack[inst][i]) begin
          fu_v[inst][i].valid    = 1'b1;
          fu_v[inst][i].dest_prn = PRN_W'($urandom_range(0, 63));
          fu_v[inst][i].value    = $urandom;
        end
      end else begin
        fu_v[inst][i] = '0;
      end
    end
  endtask

  function automatic logic [3:0] pending(input int inst);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = fu_v[inst][i].valid && !s_ack[inst][i];
    return p;
  endfunction

  // ---------------- reference model ----------------
  // Grant list in lane order: oldest-starved lowest index first, then a
  // circular scan from the pointer over whatever is left, up to n grants.
  task automatic model_step(input int inst);
    int          n;
    int          sl;
    int          g[$];
    logic [3:0]  req;
    logic [3:0]  taken;
    int          idx;
    int          last;
    bit          rot;
    cdb_packet_t p;
    n     = (inst == 0) ? 2 : 1;
    sl    = (inst == 0) ? 4 : 2;
    taken = '0;
    rot   = 1'b0;
    last  = 0;
    for (int i = 0; i < 4; i++) req[i] = fu_v[inst][i].valid && !sq_v[inst];
    for (int i = 0; i < 4; i++) begin
      if (req[i] && m_wait[inst][i] >= sl) begin
        g.push_back(i);
        taken[i] = 1'b1;
        break;
      end
    end
    for (int k = 0; k < 4; k++) begin
      idx = (m_rr[inst] + k) % 4;
      if (req[idx] && !taken[idx] && g.size() < n) begin
        g.push_back(idx);
        taken[idx] = 1'b1;
        rot  = 1'b1;
        last = idx;
      end
    end
    check_eq($sformatf("ack%0d", inst), 64'(s_ack[inst]), 64'(taken));
    for (int l = 0; l < n; l++) begin
      p = '0;
      if (l < g.size()) begin
        p       = fu_v[inst][g[l]];
        p.valid = 1'b1;
      end
      if (inst == 0) exp_q_a.push_back(p); else exp_q_b.push_back(p);
    end
    if (rot) m_rr[inst] = (last + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (!req[i] || taken[i]) m_wait[inst][i] = 0;
      else if (m_wait[inst][i] < sl) m_wait[inst][i]++;
    end
  endtask

  task automatic check_outputs(input int inst);
    int            n;
    logic [PW-1:0] e;
    n = (inst == 0) ? 2 : 1;
    for (int l = 0; l < n; l++) begin
      e = '0;
      if (inst == 0 && exp_q_a.size() > 0) e = exp_q_a.pop_front();
      if (inst == 1 && exp_q_b.size() > 0) e = exp_q_b.pop_front();
      check_eq($sformatf("cdb%0d_lane%0d", inst, l), 64'(cdb_of(inst, l)), 64'(e));
    end
    check_eq($sformatf("rr%0d", inst), 64'(s_rr[inst]), 64'(m_rr[inst]));
  endtask

  // One clock: sample at the falling edge, check and advance the model,
  // then return 1 time unit after the rising edge for the next drive.
  task automatic cycle();
    @(negedge clock);
    s_ack[0] = ack_a;
    s_ack[1] = ack_b;
    s_rr[0]  = int'(rr_a);
    s_rr[1]  = int'(rr_b);
    s_cdb_a0 = cdb_a[0];
    s_cdb_a1 = cdb_a[1];
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      model_step(k);
    end
    for (int i = 0; i < 4; i++) begin
      if (!sq_v[0] && fu_v[0][i].valid && !s_ack[0][i]) lat[i]++;
      else lat[i] = 0;
      if (lat[i] > max_lat) max_lat = lat[i];
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [PRN_W-1:0] d0, d3;
  logic [3:0]       pat;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    max_lat = 0;
    reset   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sq_v[k] = 1'b0;
      for (int i = 0; i < 4; i++) fu_v[k][i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    check_eq("rst_rr_a", 64'(rr_a), 64'd0);
    check_eq("rst_cdb_a_valid", 64'({cdb_a[1].valid, cdb_a[0].valid}), 64'd0);

    // All four requesting; instance 1 runs into its starvation guard.
    drive(0, 4'b1111, 1'b0); drive(1, 4'b1111, 1'b0); cycle();
    check_eq("all_c0_a", 64'(s_ack[0]), 64'b0011);
    check_eq("starve_c0_b", 64'(s_ack[1]), 64'b0001);
    drive(0, 4'b1111, 1'b0); drive(1, 4'b1111, 1'b0); cycle();
    check_eq("all_c1_a", 64'(s_ack[0]), 64'b1100);
    check_eq("starve_c1_b", 64'(s_ack[1]), 64'b0010);
    drive(0, 4'b1111, 1'b0); drive(1, 4'b1111, 1'b0); cycle();
    check_eq("all_c2_a", 64'(s_ack[0]), 64'b0011);
    check_eq("starve_c2_b", 64'(s_ack[1]), 64'b0100);
    drive(0, 4'b0100, 1'b0); drive(1, 4'b1111, 1'b0); cycle();
    check_eq("to_rr3_a", 64'(s_ack[0]), 64'b0100);
    check_eq("starve_c3_b", 64'(s_ack[1]), 64'b0001);
    check_eq("starve_rr_hold_b", 64'(s_rr[1]), 64'd2);

    // Wrap: pointer at 3 with requests 3 and 0.
    drive(0, 4'b1001, 1'b0); drive(1, 4'b0000, 1'b0);
    d3 = fu_v[0][3].dest_prn;
    d0 = fu_v[0][0].dest_prn;
    cycle();
    check_eq("wrap_ack", 64'(s_ack[0]), 64'b1001);
    check_eq("starve_rr_after_b", 64'(s_rr[1]), 64'd2);
    drive(0, 4'b0000, 1'b0); cycle();
    check_eq("wrap_rr", 64'(s_rr[0]), 64'd1);
    check_eq("wrap_lane0_prn", 64'(s_cdb_a0.dest_prn), 64'(d3));
    check_eq("wrap_lane1_prn", 64'(s_cdb_a1.dest_prn), 64'(d0));

    // Data integrity on a known payload.
    drive(0, 4'b0010, 1'b0);
    fu_v[0][1].dest_prn = PRN_W'(5);
    fu_v[0][1].value    = 32'hDEAD_BEEF;
    cycle();
    drive(0, 4'b0000, 1'b0); cycle();
    check_eq("data_lane0", 64'(s_cdb_a0), 64'({1'b1, 6'd5, 32'hDEAD_BEEF}));
    check_eq("data_lane1_valid", 64'(s_cdb_a1.valid), 64'd0);

    // Squash with every requester active.
    drive(0, 4'b1111, 1'b1); cycle();
    check_eq("squash_ack", 64'(s_ack[0]), 64'b0000);
    drive(0, 4'b1111, 1'b0); cycle();
    check_eq("squash_cdb_valid", 64'({s_cdb_a1.valid, s_cdb_a0.valid}), 64'd0);
    check_eq("squash_rr_held", 64'(s_rr[0]), 64'd2);
    check_eq("post_squash_ack", 64'(s_ack[0]), 64'b1100);

    // Reset while a broadcast is on the bus.
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_mid_cdb_a", 64'({cdb_a[1].valid, cdb_a[0].valid}), 64'd0);
    check_eq("rst_mid_ack_a", 64'(ack_a), 64'd0);
    check_eq("rst_mid_ack_b", 64'(ack_b), 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    check_eq("rst_rel_rr_a", 64'(rr_a), 64'd0);
    check_eq("rst_rel_rr_b", 64'(rr_b), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        pat = pending(k) | 4'($urandom_range(0, 15));
        drive(k, pat, ($urandom_range(0, 19) == 0));
      end
      cycle();
    end
    check_eq("max_wait_a_bounded", 64'(max_lat <= 4), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
